// File: rtl/output_monitor.sv
// output_monitor
//   Watches a processor OUTPUT bus and compares each change against a
//   preloaded table of expected words. Each change seen during a run uses
//   the next table entry in order. The block counts matches and mismatches
//   and records the table index of the first mismatch.
//
// Parameters
//   WIDTH         width of OUTPUT_IN and of each expected word
//   DEPTH         number of table entries (power of two, max 32)
// Ports
//   ClK           clock, rising edge
//   RESET         asynchronous active-low reset
//   LOAD_EN       append LOAD_DATA to the table (IDLE only)
//   LOAD_DATA     expected word to store
//   START         begin or restart a checking run
//   OUTPUT_IN     monitored processor output bus
//   EVT_VALID     one-cycle pulse per detected OUTPUT_IN change
//   EVT_MATCH     compare result of the current event (valid with EVT_VALID)
//   MATCH_CNT     matched events in the current run
//   MISMATCH_CNT  mismatched events in the current run
//   ERR           sticky, set on the first mismatch of a run
//   FIRST_ERR_IDX table index of the first mismatch
//   DONE          high while the last table entry has been consumed
module output_monitor #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic             ClK,
    input  logic             RESET,
    input  logic             LOAD_EN,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             START,
    input  logic [WIDTH-1:0] OUTPUT_IN,
    output logic             EVT_VALID,
    output logic             EVT_MATCH,
    output logic [5:0]       MATCH_CNT,
    output logic [5:0]       MISMATCH_CNT,
    output logic             ERR,
    output logic [5:0]       FIRST_ERR_IDX,
    output logic             DONE
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_ld_ptr;      // also the entry count N
    logic [5:0]       r_idx;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_table [DEPTH];

    logic             w_load;
    logic             w_start_idle;
    logic             w_enter;
    logic             w_evt;
    logic             w_match;
    logic             w_last;
    logic [WIDTH-1:0] w_rd;

    // A load request always wins over START in the same IDLE cycle, even
    // when the table is already full and the write itself is dropped.
    assign w_load       = (r_state == ST_IDLE) && LOAD_EN && (r_ld_ptr != 6'(DEPTH));
    assign w_start_idle = (r_state == ST_IDLE) && START && !LOAD_EN && (r_ld_ptr != 6'd0);
    assign w_enter      = w_start_idle || ((r_state == ST_DONE) && START);

    assign w_evt   = (r_state == ST_RUN) && (OUTPUT_IN != r_prev);
    assign w_rd    = r_table[r_idx[AW-1:0]];
    assign w_match = (OUTPUT_IN == w_rd);
    assign w_last  = ((r_idx + 6'd1) == r_ld_ptr);

    assign DONE = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_idle)     w_state_nxt = ST_RUN;
            ST_RUN:  if (w_evt && w_last)  w_state_nxt = ST_DONE;
            ST_DONE: if (START)            w_state_nxt = ST_RUN;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ClK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Table has no reset so it can map onto distributed RAM.
    always_ff @(posedge ClK) begin
        if (w_load) begin
            r_table[r_ld_ptr[AW-1:0]] <= LOAD_DATA;
        end
    end

    always_ff @(posedge ClK or negedge RESET) begin
        if (!RESET) begin
            r_ld_ptr      <= '0;
            r_idx         <= '0;
            r_prev        <= '0;
            MATCH_CNT     <= '0;
            MISMATCH_CNT  <= '0;
            EVT_VALID     <= 1'b0;
            EVT_MATCH     <= 1'b0;
            ERR           <= 1'b0;
            FIRST_ERR_IDX <= '0;
        end else begin
            EVT_VALID <= w_evt;
            EVT_MATCH <= w_evt && w_match;

            if (w_load) begin
                r_ld_ptr <= r_ld_ptr + 6'd1;
            end

            if (w_enter) begin
                // Capture the current bus value as the baseline so the
                // value present at START never counts as a change.
                r_prev        <= OUTPUT_IN;
                r_idx         <= '0;
                MATCH_CNT     <= '0;
                MISMATCH_CNT  <= '0;
                ERR           <= 1'b0;
                FIRST_ERR_IDX <= '0;
            end else if (r_state == ST_RUN) begin
                r_prev <= OUTPUT_IN;
                if (w_evt) begin
                    r_idx <= r_idx + 6'd1;
                    if (w_match) begin
                        MATCH_CNT <= MATCH_CNT + 6'd1;
                    end else begin
                        MISMATCH_CNT <= MISMATCH_CNT + 6'd1;
                        if (!ERR) begin
                            ERR           <= 1'b1;
                            FIRST_ERR_IDX <= r_idx;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_output_monitor.sv
// tb_output_monitor
//   Self-checking bench for output_monitor. A behavioural model (queue of
//   expected words plus running tallies) predicts every output after each
//   clock edge; directed scenarios are followed by randomized runs.
module tb_output_monitor;

    logic        ClK = 1'b0;
    logic        RESET;
    logic        LOAD_EN;
    logic [15:0] LOAD_DATA;
    logic        START;
    logic [15:0] OUTPUT_IN;
    logic        EVT_VALID;
    logic        EVT_MATCH;
    logic [5:0]  MATCH_CNT;
    logic [5:0]  MISMATCH_CNT;
    logic        ERR;
    logic [5:0]  FIRST_ERR_IDX;
    logic        DONE;

    always #5 ClK = ~ClK;

    output_monitor #(.WIDTH(16), .DEPTH(32)) dut (
        .ClK          (ClK),
        .RESET        (RESET),
        .LOAD_EN      (LOAD_EN),
        .LOAD_DATA    (LOAD_DATA),
        .START        (START),
        .OUTPUT_IN    (OUTPUT_IN),
        .EVT_VALID    (EVT_VALID),
        .EVT_MATCH    (EVT_MATCH),
        .MATCH_CNT    (MATCH_CNT),
        .MISMATCH_CNT (MISMATCH_CNT),
        .ERR          (ERR),
        .FIRST_ERR_IDX(FIRST_ERR_IDX),
        .DONE         (DONE)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected table as a queue, run phase as a flag pair.
    logic [15:0] m_tab[$];
    bit          m_running;
    bit          m_finished;
    logic [15:0] m_prev;
    int          m_mc, m_mmc, m_err, m_fei, m_ev, m_em;

    function automatic void model_reset();
        m_tab.delete();
        m_running = 0; m_finished = 0; m_prev = '0;
        m_mc = 0; m_mmc = 0; m_err = 0; m_fei = 0; m_ev = 0; m_em = 0;
    endfunction

    function automatic void model_begin_run();
        m_running = 1; m_finished = 0; m_prev = OUTPUT_IN;
        m_mc = 0; m_mmc = 0; m_err = 0; m_fei = 0;
    endfunction

    // Predict the effect of the coming clock edge from the current inputs.
    function automatic void model_step();
        int pos;
        m_ev = 0; m_em = 0;
        if (m_running) begin
            if (OUTPUT_IN != m_prev) begin
                pos  = m_mc + m_mmc;
                m_ev = 1;
                m_em = (OUTPUT_IN == m_tab[pos]) ? 1 : 0;
                if (m_em != 0) m_mc++;
                else begin
                    if (m_err == 0) begin m_err = 1; m_fei = pos; end
                    m_mmc++;
                end
                if (m_mc + m_mmc == m_tab.size()) begin
                    m_running = 0; m_finished = 1;
                end
            end
            m_prev = OUTPUT_IN;
        end else if (m_finished) begin
            if (START) model_begin_run();
        end else begin
            if (LOAD_EN) begin
                if (m_tab.size() < 32) m_tab.push_back(LOAD_DATA);
            end else if (START && m_tab.size() > 0) begin
                model_begin_run();
            end
        end
    endfunction

    task automatic check_all();
        check("evt_valid", int'(EVT_VALID), m_ev);
        if (m_ev != 0) check("evt_match", int'(EVT_MATCH), m_em);
        check("match_cnt", int'(MATCH_CNT), m_mc);
        check("mismatch_cnt", int'(MISMATCH_CNT), m_mmc);
        check("err", int'(ERR), m_err);
        check("first_err_idx", int'(FIRST_ERR_IDX), m_fei);
        check("done", int'(DONE), int'(m_finished));
    endtask

    task automatic tick();
        model_step();
        @(posedge ClK);
        #1;
        check_all();
    endtask

    task automatic drive(input logic le, input logic [15:0] ld, input logic st, input logic [15:0] oi);
        LOAD_EN = le; LOAD_DATA = ld; START = st; OUTPUT_IN = oi;
        tick();
    endtask

    // Assert reset between edges, check outputs before any clock edge, then
    // release just after the following rising edge.
    task automatic reset_async();
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        check("rst_evt_valid", int'(EVT_VALID), 0);
        check("rst_evt_match", int'(EVT_MATCH), 0);
        check("rst_match_cnt", int'(MATCH_CNT), 0);
        check("rst_mismatch_cnt", int'(MISMATCH_CNT), 0);
        check("rst_err", int'(ERR), 0);
        check("rst_first_err_idx", int'(FIRST_ERR_IDX), 0);
        check("rst_done", int'(DONE), 0);
        @(posedge ClK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        drive(1'b1, w0, 1'b0, OUTPUT_IN);
        drive(1'b1, w1, 1'b0, OUTPUT_IN);
        drive(1'b1, w2, 1'b0, OUTPUT_IN);
    endtask

    initial begin
        RESET = 1'b0; LOAD_EN = 1'b0; LOAD_DATA = '0; START = 1'b0; OUTPUT_IN = '0;
        model_reset();
        #1;
        check_all();
        @(posedge ClK);
        #1;
        RESET = 1'b1;

        // Three-word table, all matching, back-to-back changes.
        load_words(16'h0001, 16'h0002, 16'h0003);
        drive(1'b0, '0, 1'b1, 16'h0000);
        drive(1'b0, '0, 1'b0, 16'h0001);
        drive(1'b0, '0, 1'b0, 16'h0002);
        drive(1'b0, '0, 1'b0, 16'h0003);
        check("s1_match_cnt", int'(MATCH_CNT), 3);
        check("s1_err", int'(ERR), 0);
        check("s1_done", int'(DONE), 1);

        // Rerun with one mismatch at index 1.
        drive(1'b0, '0, 1'b1, 16'h0003);
        drive(1'b0, '0, 1'b0, 16'h0001);
        drive(1'b0, '0, 1'b0, 16'h00FF);
        drive(1'b0, '0, 1'b0, 16'h0003);
        check("s2_match_cnt", int'(MATCH_CNT), 2);
        check("s2_mismatch_cnt", int'(MISMATCH_CNT), 1);
        check("s2_err", int'(ERR), 1);
        check("s2_first_err_idx", int'(FIRST_ERR_IDX), 1);
        drive(1'b0, '0, 1'b0, 16'h0055);   // ignored in DONE
        check("s2_hold_mismatch", int'(MISMATCH_CNT), 1);

        // From DONE with ERR set, restart and match fully.
        drive(1'b0, '0, 1'b1, 16'h0055);
        check("s3_err_cleared", int'(ERR), 0);
        check("s3_cnt_cleared", int'(MATCH_CNT), 0);
        drive(1'b1, 16'h0777, 1'b1, 16'h0001);   // LOAD_EN/START ignored in RUN
        drive(1'b0, '0, 1'b0, 16'h0002);
        drive(1'b0, '0, 1'b0, 16'h0003);
        check("s3_match_cnt", int'(MATCH_CNT), 3);
        check("s3_err", int'(ERR), 0);

        // Constant bus for 50 cycles, then three consecutive changes.
        drive(1'b0, '0, 1'b1, 16'h0003);
        for (int i = 0; i < 50; i++) drive(1'b0, '0, 1'b0, 16'h0003);
        drive(1'b0, '0, 1'b0, 16'h0001);
        drive(1'b0, '0, 1'b0, 16'h0002);
        drive(1'b0, '0, 1'b0, 16'h0003);

        // Reset in the middle of a run; START afterwards must be ignored.
        drive(1'b0, '0, 1'b1, 16'h0000);
        drive(1'b0, '0, 1'b0, 16'h0001);
        reset_async();
        drive(1'b0, '0, 1'b1, 16'h0001);
        drive(1'b0, '0, 1'b0, 16'h0002);
        check("s5_idle_done", int'(DONE), 0);
        check("s5_idle_evt", int'(EVT_VALID), 0);

        // Fill past capacity; LOAD_EN+START together on the dropped 33rd word.
        for (int i = 0; i < 33; i++)
            drive(1'b1, 16'h4000 + 16'(i), (i == 32), 16'h0000);
        drive(1'b0, '0, 1'b0, 16'h1234);
        check("s6_stay_idle_evt", int'(EVT_VALID), 0);
        drive(1'b0, '0, 1'b1, 16'h0000);
        for (int i = 0; i < 32; i++) drive(1'b0, '0, 1'b0, 16'h4000 + 16'(i));
        check("s6_full_match", int'(MATCH_CNT), 32);
        check("s6_full_done", int'(DONE), 1);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            int k;
            reset_async();
            k = $urandom_range(1, 8);
            for (int i = 0; i < k; i++)
                drive(1'b1, 16'($urandom_range(0, 7)), 1'b0, OUTPUT_IN);
            for (int c = 0; c < 60; c++) begin
                int sel;
                logic [15:0] oi;
                sel = $urandom_range(0, 9);
                if (sel < 5) oi = OUTPUT_IN;
                else if (sel < 8) oi = m_tab[(m_mc + m_mmc) % m_tab.size()];
                else oi = 16'($urandom_range(0, 7));
                drive(($urandom_range(0, 19) == 0), 16'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0) || (c == 0), oi);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/output_monitor.md
OUTPUT_MONITOR -- requirements
Module: output_monitor

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- WIDTH, 16, width of the monitored processor OUTPUT bus and of each expected word.
- DEPTH, 32, number of expected-word entries; power of two, maximum 32.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- ClK, input, 1, single clock; all state changes on the rising edge.
- RESET, input, 1, asynchronous, active-low reset.
- LOAD_EN, input, 1, write LOAD_DATA into the expected table (IDLE only).
- LOAD_DATA, input, WIDTH, expected word to store.
- START, input, 1, begin or restart a checking run.
- OUTPUT_IN, input, WIDTH, the processor OUTPUT bus under observation.
- EVT_VALID, output, 1, one-cycle pulse, one per detected OUTPUT_IN change.
- EVT_MATCH, output, 1, compare result for the current event; valid only with EVT_VALID.
- MATCH_CNT, output, 6, number of matched events in the current run.
- MISMATCH_CNT, output, 6, number of mismatched events in the current run.
- ERR, output, 1, sticky; set on the first mismatch of a run.
- FIRST_ERR_IDX, output, 6, table index of the first mismatch.
- DONE, output, 1, high while in DONE state.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-004 In IDLE, LOAD_EN=1 SHALL write LOAD_DATA to table[ld_ptr] and increment ld_ptr; N (entry count) = ld_ptr.
REQ-005 LOAD_EN while ld_ptr=DEPTH SHALL be ignored: no write, no wrap.
REQ-006 LOAD_EN in RUN or DONE SHALL be ignored.
REQ-007 If LOAD_EN and START are high in the same IDLE cycle, load SHALL take priority and START SHALL be ignored.
REQ-008 START in IDLE with N>0 SHALL move to RUN; START with N=0 SHALL be ignored.
REQ-009 The edge that enters RUN SHALL do all of the following:
- set prev_q<=OUTPUT_IN;
- clear idx, MATCH_CNT, MISMATCH_CNT, ERR and FIRST_ERR_IDX.
No event SHALL be generated for the initial value.
REQ-010 At every rising edge in RUN, prev_q<=OUTPUT_IN.
REQ-011 An event SHALL occur at a RUN edge where OUTPUT_IN != prev_q. On that edge:
- EVT_VALID<=1;
- EVT_MATCH<=(OUTPUT_IN==table[idx]);
- the matching counter increments;
- idx<=idx+1.
REQ-012 Event latency SHALL be one cycle: the change is sampled at edge k, and the result is visible from edge k until edge k+1.
REQ-013 EVT_VALID SHALL be low in every cycle without an event; consecutive-cycle changes SHALL produce back-to-back pulses.
REQ-014 On a mismatch while ERR=0, the block SHALL set ERR=1 and FIRST_ERR_IDX<=idx. Later mismatches SHALL NOT alter FIRST_ERR_IDX.
REQ-015 The event that consumes entry N-1 SHALL move the FSM to DONE on the same edge; further OUTPUT_IN changes SHALL be ignored.
REQ-016 In DONE, the counters, ERR and FIRST_ERR_IDX SHALL hold. START SHALL re-enter RUN per REQ-009, with the table and N retained.
REQ-017 MATCH_CNT+MISMATCH_CNT SHALL always equal idx. Counters SHALL never exceed N, so no overflow is possible.
REQ-018 START asserted while in RUN SHALL be ignored.
REQ-019 Table reads SHALL be combinational from idx; the table SHALL be inferable as distributed RAM.

Reset
REQ-020 When RESET=0, the block SHALL immediately, without waiting for ClK:
- enter IDLE;
- clear ld_ptr, N, idx, prev_q and both counters;
- clear EVT_VALID, EVT_MATCH, ERR, FIRST_ERR_IDX and DONE.
Table contents are unspecified.
REQ-021 Reset asserted mid-RUN SHALL abort the run. After release, N=0, so a new load is required before START is accepted.
REQ-022 Outputs SHALL be stable from the first edge after RESET deasserts. RESET release is synchronous to ClK by system design.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load 3 words {0x0001,0x0002,0x0003}, START, drive OUTPUT_IN 0x0000->0x0001->0x0002->0x0003 -> three EVT_VALID pulses, all EVT_MATCH=1; MATCH_CNT=3, ERR=0, DONE=1.
- Same table, drive 0x0001->0x00FF->0x0003 -> MATCH_CNT=2, MISMATCH_CNT=1, ERR=1, FIRST_ERR_IDX=1.
- Load 33 words -> N=32, 33rd word dropped; LOAD_EN+START in the same cycle -> stays IDLE.
- OUTPUT_IN held constant for 50 cycles in RUN -> no EVT_VALID. A change on each of 3 consecutive edges -> 3 back-to-back pulses.
- RESET low mid-RUN between clock edges -> all outputs 0 immediately; START after release with no load -> remains IDLE.
- From DONE with ERR=1, START and a fully matching sequence -> ERR=0, counters restart from 0.
